seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential shift-and-add multiplier: the clocked successor to the team's 4x4 combinational array multiplier. It trades area for latency, using one WIDTH-bit adder reused over WIDTH cycles instead of a WIDTH-deep adder array. Operands are accepted with a start/busy/done handshake, and the 2*WIDTH-bit product is held in a register until the next completion. The block sits in the datapath wherever a multiply is needed but a single-cycle array is too large for the chosen WIDTH.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand, captured on the accepting edge.
- b  in  WIDTH  multiplier, captured on the accepting edge.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse; product is valid from this cycle.
- product  out  2*WIDTH  registered result; held until the next done.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE when the iteration count reaches WIDTH.
  - DONE → IDLE unconditionally.
- Accept (IDLE, start=1):
  - Latch multiplicand register M=a.
  - Load accumulator ACC[2W-1:0] = {W'b0, b}.
  - Clear counter cnt=0.
- Each RUN cycle:
  - If ACC[0]=1, compute {carry, hi} = ACC[2W-1:W] + M; otherwise {carry, hi} = {1'b0, ACC[2W-1:W]}.
  - ACC ← {carry, hi, ACC[W-1:1]}, a logical right shift that brings in the adder carry.
  - cnt ← cnt+1.
  - cnt is $clog2(WIDTH+1) bits wide.
- Arithmetic uses a WIDTH+1-bit add, so no overflow is possible; the final ACC equals a*b exactly.
- On the RUN→DONE edge, product ← ACC (final value).
- start is ignored outside IDLE, including in DONE; a and b may change freely while busy.
- product is not cleared by a new start; it changes only on the RUN→DONE edge or on reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, product=0, ACC=0, M=0, cnt=0.
  - All outputs are registered; no combinational path from any input to any output.
- Start accepted at edge t0 → busy=1 from t0.
- RUN iterations occur at edges t0+1 … t0+WIDTH. At edge t0+WIDTH, state becomes DONE and product is updated.
- done=1 for exactly the cycle after edge t0+WIDTH. Latency is therefore WIDTH cycles from the accepting edge to done.
- Edge t0+WIDTH+1 returns the FSM to IDLE (busy=0). The earliest next accept is edge t0+WIDTH+2, giving a throughput of one multiply per WIDTH+2 cycles.
- Reset asserted mid-operation: immediate return to IDLE, product=0, no done pulse. After release, the first start behaves as after power-up.
- start held high continuously: a new operation is accepted every WIDTH+2 cycles, each using the a and b values present on its accepting edge.

## Configuration
- SEQ_MULT_SIGNED_EN defined: a, b and product are two's complement.
  - Accept: latch |a| and |b|, plus neg = a[W-1]^b[W-1].
  - RUN: identical unsigned iterations.
  - RUN→DONE: product ← neg ? -ACC : ACC.
  - Most-negative operands are handled as magnitude 2^(W-1); the result always fits in 2*WIDTH bits.
  - Latency is unchanged.
- Not defined: unsigned operation only, and no sign logic is synthesised.

## Test plan
- WIDTH=4, reset then a=15, b=15, start for 1 cycle → busy high from the accepting edge; done pulses exactly 4 cycles later with product=8'hE1 (225); busy low one cycle after done.
- WIDTH=4, a=11, b=13, then a=0, b=9 back-to-back with start held high → products 143 and then 0, done pulses 6 cycles apart; product holds 143 until the second done.
- WIDTH=4, accept a=3, b=5, then pulse start with a=7, b=7 during RUN and again during DONE → both pulses ignored; product=15.
- WIDTH=4, accept a=9, b=9, assert rst_n=0 two cycles later → busy, done and product go to 0 immediately; no done pulse; a subsequent a=2, b=6 run gives 12.
- WIDTH=8 → 255*255 gives 16'hFE01 with done 8 cycles after accept; WIDTH=2 → 3*3 gives 4'h9 after 2 cycles.
- WIDTH=4 with SEQ_MULT_SIGNED_EN → -8*-8 gives 8'h40; -3*5 gives 8'hF1; 7*-1 gives 8'hF9; latency still 4 cycles.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one WIDTH+1-bit adder reused over WIDTH cycles,
// start/busy/done handshake. Define SEQ_MULT_SIGNED_EN for two's-complement operands/product.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     m;
    logic [2*WIDTH-1:0]   acc, acc_nxt, prod_fin;
    logic [CW-1:0]        cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 last;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    // Most-negative value negates to itself, which read unsigned is the correct magnitude.
    assign a_mag    = a[WIDTH-1] ? -a : a;
    assign b_mag    = b[WIDTH-1] ? -b : b;
    assign prod_fin = neg ? -acc_nxt : acc_nxt;
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign prod_fin = acc_nxt;
`endif

    assign sum     = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign acc_nxt = {sum, acc[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    m   <= a_mag;
                    acc <= {{WIDTH{1'b0}}, b_mag};
                    cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) product <= prod_fin;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH 4, 8 and 2.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s4 = 1'b0, s8 = 1'b0, s2 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [1:0] a2 = '0, b2 = '0;
    logic bz4, bz8, bz2, dn4, dn8, dn2;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [3:0]  p2;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
                                      .busy(bz4), .done(dn4), .product(p4));
    seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
                                      .busy(bz8), .done(dn8), .product(p8));
    seq_multiplier #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
                                      .busy(bz2), .done(dn2), .product(p2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? bz8 : (w == 2) ? bz2 : bz4;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 8) ? dn8 : (w == 2) ? dn2 : dn4;
    endfunction
    function automatic logic [31:0] get_prod(input int w);
        return (w == 8) ? 32'(p8) : (w == 2) ? 32'(p2) : 32'(p4);
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv);
        case (w)
            8:       begin s8 = st; a8 = av[7:0]; b8 = bv[7:0]; end
            2:       begin s2 = st; a2 = av[1:0]; b2 = bv[1:0]; end
            default: begin s4 = st; a4 = av[3:0]; b4 = bv[3:0]; end
        endcase
    endtask

    // Count negedges from the accepting edge until done, bounded.
    task automatic wait_done(input int w, output int n);
        n = 0;
        while (!get_done(w) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input string tag, input int w, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] exp);
        int n;
        @(negedge clk);
        drive(w, 1'b1, av, bv);
        @(negedge clk);
        drive(w, 1'b0, 0, 0);
        chk({tag, " busy"}, 32'(get_busy(w)), 1);
        wait_done(w, n);
        chk({tag, " latency"}, n, w);
        chk({tag, " product"}, get_prod(w), exp);
        @(negedge clk);
        chk({tag, " done width"}, 32'(get_done(w)), 0);
        chk({tag, " busy after"}, 32'(get_busy(w)), 0);
    endtask

    initial begin
        int n, gap;
        logic held, seen;
        #1;
        chk("reset busy", 32'(bz4), 0);
        chk("reset done", 32'(dn4), 0);
        chk("reset product", 32'(p4), 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
        op("s -8*-8", 4, 32'h8, 32'h8, 32'h40);
        op("s -3*5", 4, 32'hD, 32'h5, 32'hF1);
        op("s 7*-1", 4, 32'h7, 32'hF, 32'hF9);
        op("s 3*5", 4, 32'h3, 32'h5, 32'h0F);
`else
        op("15*15", 4, 15, 15, 32'hE1);

        // back-to-back with start held high
        @(negedge clk);
        drive(4, 1'b1, 11, 13);
        @(negedge clk);
        drive(4, 1'b1, 0, 9);
        wait_done(4, n);
        chk("b2b first latency", n, 4);
        chk("b2b first product", 32'(p4), 143);
        gap = 0;
        held = 1'b1;
        @(negedge clk);
        gap++;
        while (!dn4 && gap < 40) begin
            if (p4 != 8'd143) held = 1'b0;
            @(negedge clk);
            gap++;
        end
        drive(4, 1'b0, 0, 0);
        chk("b2b done spacing", gap, 6);
        chk("b2b product held", 32'(held), 1);
        chk("b2b second product", 32'(p4), 0);
        @(negedge clk);
        @(negedge clk);

        // start pulses during RUN and DONE are ignored
        @(negedge clk);
        drive(4, 1'b1, 3, 5);
        @(negedge clk);
        drive(4, 1'b0, 0, 0);
        @(negedge clk);
        drive(4, 1'b1, 7, 7);
        @(negedge clk);
        drive(4, 1'b0, 0, 0);
        wait_done(4, n);
        chk("ign latency", n, 2);
        chk("ign product", 32'(p4), 15);
        drive(4, 1'b1, 7, 7);
        @(negedge clk);
        drive(4, 1'b0, 0, 0);
        chk("ign busy after done", 32'(bz4), 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dn4 || bz4) seen = 1'b1;
        end
        chk("ign no extra op", 32'(seen), 0);
        chk("ign product kept", 32'(p4), 15);

        // reset mid-operation
        @(negedge clk);
        drive(4, 1'b1, 9, 9);
        @(negedge clk);
        drive(4, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(bz4), 0);
        chk("rst done", 32'(dn4), 0);
        chk("rst product", 32'(p4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dn4) seen = 1'b1;
        end
        chk("rst no done", 32'(seen), 0);
        op("2*6", 4, 2, 6, 12);

        op("w8 255*255", 8, 255, 255, 32'hFE01);
        op("w8 200*3", 8, 200, 3, 600);
        op("w2 3*3", 2, 3, 3, 9);
        op("w2 2*1", 2, 2, 1, 2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
